// File: rtl/seq_mag_comparator.sv
// seq_mag_comparator: bit-serial magnitude comparator.
// Captures A/B/signed_mode on start and walks the operands MSB-first, one bit
// pair per cycle. It stops at the first differing bit, or at bit 0 if the
// operands are equal. The result flags are registered and one-hot after the
// first completed comparison.
module seq_mag_comparator #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             A_greater_B,
    output logic             A_less_B,
    output logic             A_equal_B
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] IDX_MSB = IW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t          r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic            r_signed;
    logic [IW-1:0]   r_idx;
    logic            r_busy;
    logic            r_done;
    logic            r_gt;
    logic            r_lt;
    logic            r_eq;

    logic            w_bit_a;
    logic            w_bit_b;
    logic            w_at_msb;
    logic            w_gt;

    assign w_bit_a  = r_a[r_idx];
    assign w_bit_b  = r_b[r_idx];
    assign w_at_msb = (r_idx == IDX_MSB);
    // A set bit in A at the first difference means A is larger. The exception
    // is the sign bit in two's-complement mode, where a set bit means negative.
    assign w_gt     = w_bit_a ^ (r_signed & w_at_msb);

    // Sequencer plus registered outputs. The flags change only on DONE entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_signed <= 1'b0;
            r_idx    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_gt     <= 1'b0;
            r_lt     <= 1'b0;
            r_eq     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a      <= A;
                        r_b      <= B;
                        r_signed <= signed_mode;
                        r_idx    <= IDX_MSB;
                        r_busy   <= 1'b1;
                        r_state  <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (w_bit_a != w_bit_b) begin
                        r_gt    <= w_gt;
                        r_lt    <= ~w_gt;
                        r_eq    <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else if (r_idx == '0) begin
                        r_gt    <= 1'b0;
                        r_lt    <= 1'b0;
                        r_eq    <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        // Decrement only when above zero, so the index cannot wrap.
                        r_idx <= r_idx - 1'b1;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign A_greater_B = r_gt;
    assign A_less_B    = r_lt;
    assign A_equal_B   = r_eq;

endmodule

// File: tb/tb_seq_mag_comparator.sv
// Testbench for seq_mag_comparator (WIDTH=8).
// A transaction-level model predicts the outputs, and the DUT is compared
// against it on every cycle. Directed cases pin the model to literal values.
module tb_seq_mag_comparator;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic         signed_mode = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         busy, done, A_greater_B, A_less_B, A_equal_B;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    seq_mag_comparator #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
        .A(A), .B(B), .busy(busy), .done(done),
        .A_greater_B(A_greater_B), .A_less_B(A_less_B), .A_equal_B(A_equal_B)
    );

    always #5 clk = ~clk;

    // Expected {gt,lt,eq} from plain arithmetic comparison.
    function automatic logic [2:0] ref_flags(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic sm);
        logic signed [W-1:0] sa, sb;
        sa = a;
        sb = b;
        if (sm) return (sa > sb) ? 3'b100 : (sa < sb) ? 3'b010 : 3'b001;
        else    return (a > b)   ? 3'b100 : (a < b)   ? 3'b010 : 3'b001;
    endfunction

    // Serial cost: one cycle per bit scanned, through the first differing bit.
    function automatic int ref_shifts(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] x;
        x = a ^ b;
        if (x == '0) return W;
        for (int k = W - 1; k >= 0; k--)
            if (x[k]) return W - k;
        return W;
    endfunction

    // Model state: the pending result and the number of scan cycles left.
    logic       m_busy = 1'b0, m_done = 1'b0;
    logic [2:0] m_flags = 3'b000, m_res = 3'b000;
    int         m_left = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy  <= 1'b0;
            m_done  <= 1'b0;
            m_flags <= 3'b000;
            m_left  <= 0;
        end else if (m_done) begin
            m_done <= 1'b0;
            m_busy <= 1'b0;
        end else if (m_busy) begin
            if (m_left == 1) begin
                m_done  <= 1'b1;
                m_flags <= m_res;
            end
            m_left <= m_left - 1;
        end else if (start) begin
            m_busy <= 1'b1;
            m_left <= ref_shifts(A, B);
            m_res  <= ref_flags(A, B, signed_mode);
        end
    end

    // Per-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            total++;
            if ({busy, done, A_greater_B, A_less_B, A_equal_B} !== {m_busy, m_done, m_flags}) begin
                bad++;
                $display("FAIL cycle t=%0t got bsy/dn/gt/lt/eq=%b want=%b", $time,
                         {busy, done, A_greater_B, A_less_B, A_equal_B}, {m_busy, m_done, m_flags});
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    // One start pulse, then count the scan cycles until done and check the literal result.
    task automatic run_cmp(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic sm, input logic [2:0] want_flags, input int want_n);
        int n;
        A = a; B = b; signed_mode = sm; start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!done && n < 40) begin
            n++;
            tick();
        end
        check({name, "_done"}, 32'(done), 32'd1);
        check({name, "_shifts"}, 32'(n), 32'(want_n));
        check({name, "_flags"}, 32'({A_greater_B, A_less_B, A_equal_B}), 32'(want_flags));
        tick();
    endtask

    initial begin
        int n, pulses;
        // Reset with no clock edge yet.
        #1 rst_n = 1'b0;
        #1;
        check("reset_outs", 32'({busy, done, A_greater_B, A_less_B, A_equal_B}), 32'd0);
        tick();
        rst_n = 1'b1;
        chk_en = 1'b1;
        tick();

        run_cmp("u80_7f", 8'h80, 8'h7F, 1'b0, 3'b100, 1);
        run_cmp("s80_7f", 8'h80, 8'h7F, 1'b1, 3'b010, 1);
        run_cmp("eq5a",   8'h5A, 8'h5A, 1'b0, 3'b001, 8);
        run_cmp("u05_04", 8'h05, 8'h04, 1'b0, 3'b100, 8);
        run_cmp("sff_01", 8'hFF, 8'h01, 1'b1, 3'b010, 1);

        // Operands change and start is re-asserted while busy; 0x10 vs 0x20 differ at bit 5.
        A = 8'h10; B = 8'h20; signed_mode = 1'b0; start = 1'b1;
        tick();
        start = 1'b0; A = 8'hFF;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) begin
                pulses++;
                check("busy_start_flags", 32'({A_greater_B, A_less_B, A_equal_B}), 32'b010);
            end
            tick();
        end
        check("busy_start_pulses", 32'(pulses), 32'd1);

        // Reset during the 4th scan cycle of an equal compare.
        A = 8'h3C; B = 8'h3C; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        rst_n = 1'b0;
        #1;
        check("midrst_outs", 32'({busy, done, A_greater_B, A_less_B, A_equal_B}), 32'd0);
        tick();
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (done) n++;
            tick();
        end
        check("midrst_nodone", 32'(n), 32'd0);
        // 0x01 vs 0x02 first differ at bit 1, so 7 scan cycles.
        run_cmp("post_rst", 8'h01, 8'h02, 1'b0, 3'b010, 7);

        // Random traffic: the per-cycle compare does the checking.
        for (int i = 0; i < 3000; i++) begin
            start       = ($urandom_range(0, 3) == 0);
            signed_mode = $urandom_range(0, 1);
            A           = $urandom;
            case ($urandom_range(0, 3))
                0: B = A;
                1: B = {A[W-1:3], 3'($urandom)};
                default: B = $urandom;
            endcase
            if ($urandom_range(0, 199) == 0) rst_n = 1'b0;
            tick();
            rst_n = 1'b1;
        end

        // Start held high: back-to-back compares.
        A = 8'hC0; B = 8'h40; signed_mode = 1'b1; start = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        start = 1'b0;
        for (int i = 0; i < 12; i++) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog timeout got=running want=finished");
        $fatal(1);
    end

endmodule
